// File: rtl/adder_pkg.sv
// Shared definitions for the adder accumulator stage: adder width, FSM states
// and the clamp value used when the ACC_SAT_EN build option is enabled.
package adder_pkg;
  localparam int ADDER_W = 4;
  localparam logic [ADDER_W-1:0] SAT_VAL = '1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;
endpackage

// File: rtl/adder.sv
// Ripple-carry adder: S = A + B + Cin, carry chained through one full adder per bit.
module adder
  import adder_pkg::*;
#(
  parameter int W = ADDER_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout
);
  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < W; g++) begin : g_fa
    assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[W];
endmodule

// File: rtl/adder_acc_stage.sv
// Accumulator stage around the ripple-carry adder: sums a packet of beats and
// offers the result downstream. Build option ACC_SAT_EN clamps acc on carry-out.
//
// Handshakes: a beat moves on in_valid & in_ready, the result moves on
// out_valid & out_ready; valid never depends on ready, and in_ready/out_valid
// are pure decodes of the state register so they never see input paths.
// The adder is instantiated here; add_s/add_cout are driven out for observation.
module adder_acc_stage
  import adder_pkg::*;
#(
  parameter int W     = ADDER_W,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_b,
  input  logic             in_cin,
  input  logic             in_last,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_cin,
  output logic [W-1:0]     add_s,
  output logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output state_t           dbg_state
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [W-1:0]     r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic [W-1:0]     w_sum;
  logic             w_cout;
  logic [W-1:0]     w_next_acc;
  logic             w_accept;

  adder #(.W(W)) u_adder (
    .i_a    (r_acc),
    .i_b    (in_b),
    .i_cin  (in_cin),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

`ifdef ACC_SAT_EN
  assign w_next_acc = w_cout ? SAT_VAL : w_sum;
`else
  assign w_next_acc = w_sum;
`endif

  assign w_accept  = in_valid & in_ready;
  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_DONE);

  assign add_a     = r_acc;
  assign add_b     = in_b;
  assign add_cin   = in_cin;
  assign add_s     = w_sum;
  assign add_cout  = w_cout;

  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_cnt;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_acc <= w_next_acc;
            r_ovf <= r_ovf | w_cout;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            if (in_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Clearing here means the next beat can only land on the following cycle.
          if (out_ready) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_acc_stage.sv
// Directed testbench for adder_acc_stage: packet sums, wrap, backpressure,
// carry-in, reset mid-packet and beat-counter saturation.
module tb_adder_acc_stage;
  import adder_pkg::*;

  localparam int W     = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_b;
  logic             in_cin;
  logic             in_last;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic             add_cin;
  logic [W-1:0]     add_s;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;
  state_t           dbg_state;

  int n_pass;
  int n_total;

  adder_acc_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] b, input logic cin, input logic last);
    in_valid = 1'b1;
    in_b     = b;
    in_cin   = cin;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_b     = 'x;
    in_cin   = 1'bx;
    in_last  = 1'bx;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_b      = 4'd5;
    in_cin    = 1'b0;
    in_last   = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    else n_pass++;
    n_total++;
    if (add_a !== 4'd0) $display("FAIL reset_add_a got=%0d exp=0", add_a);
    else n_pass++;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    else n_pass++;
    n_total++;
    if (dbg_state !== ST_ACC || out_count !== 4'd0)
      $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, out_count);
    else n_pass++;
  endtask

  task automatic test_accumulate();
    // Adder path is combinational while idle: 0 + 6 + 1 = 7.
    in_b   = 4'd6;
    in_cin = 1'b1;
    #1;
    n_total++;
    if (add_b !== 4'd6 || add_cin !== 1'b1 || add_s !== 4'd7 || add_cout !== 1'b0)
      $display("FAIL adder_comb got=b%0d c%0b s%0d co%0b exp=b6 c1 s7 co0", add_b, add_cin, add_s, add_cout);
    else n_pass++;
    send_beat(4'd3, 1'b0, 1'b0);
    send_beat(4'd4, 1'b0, 1'b0);
    n_total++;
    if (out_valid !== 1'b0 || add_a !== 4'd7)
      $display("FAIL acc_mid got=v%0b a%0d exp=v0 a7", out_valid, add_a);
    else n_pass++;
    send_beat(4'd5, 1'b0, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL acc_latency got=v%0b r%0b exp=v1 r0", out_valid, in_ready);
    else n_pass++;
    n_total++;
    if (out_sum !== 4'd12 || out_ovf !== 1'b0 || out_count !== 4'd3)
      $display("FAIL acc_result got=%0d/%0b/%0d exp=12/0/3", out_sum, out_ovf, out_count);
    else n_pass++;
    release_result();
    n_total++;
    if (out_valid !== 1'b0 || out_sum !== 4'd0 || out_count !== 4'd0)
      $display("FAIL acc_clear got=v%0b s%0d c%0d exp=v0 s0 c0", out_valid, out_sum, out_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_sum;
`ifdef ACC_SAT_EN
    exp_sum = 4'd15;
`else
    exp_sum = 4'd2;
`endif
    send_beat(4'd9, 1'b0, 1'b0);
    send_beat(4'd9, 1'b0, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_sum !== exp_sum || out_ovf !== 1'b1 || out_count !== 4'd2)
      $display("FAIL wrap_result got=v%0b %0d/%0b/%0d exp=v1 %0d/1/2", out_valid, out_sum, out_ovf, out_count, exp_sum);
    else n_pass++;
    release_result();
    n_total++;
    if (out_ovf !== 1'b0) $display("FAIL wrap_ovf_clear got=%0b exp=0", out_ovf);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    send_beat(4'd6, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_b     = 4'd7;
    in_cin   = 1'b0;
    in_last  = 1'b1;
    bad      = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 4'd6 || out_count !== 4'd1)
        bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL bp_hold got=%0d bad cycles exp=0", bad);
    else n_pass++;
    // Handshake with in_valid still high: the held beat must not be taken this edge.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || out_sum !== 4'd0 || out_count !== 4'd0)
      $display("FAIL bp_release got=v%0b s%0d c%0d exp=v0 s0 c0", out_valid, out_sum, out_count);
    else n_pass++;
    send_beat(4'd1, 1'b0, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_sum !== 4'd1 || out_count !== 4'd1)
      $display("FAIL bp_next got=v%0b s%0d c%0d exp=v1 s1 c1", out_valid, out_sum, out_count);
    else n_pass++;
    release_result();
  endtask

  task automatic test_carry_in();
    send_beat(4'd0, 1'b1, 1'b0);
    send_beat(4'd0, 1'b1, 1'b0);
    send_beat(4'd0, 1'b1, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_sum !== 4'd3 || out_ovf !== 1'b0 || out_count !== 4'd3)
      $display("FAIL cin_result got=v%0b %0d/%0b/%0d exp=v1 3/0/3", out_valid, out_sum, out_ovf, out_count);
    else n_pass++;
    release_result();
  endtask

  task automatic test_reset_mid();
    int seen;
    send_beat(4'd7, 1'b0, 1'b0);
    send_beat(4'd6, 1'b0, 1'b0);
    n_total++;
    if (out_sum !== 4'd13 || out_count !== 4'd2)
      $display("FAIL rst_mid_partial got=%0d/%0d exp=13/2", out_sum, out_count);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (out_sum !== 4'd0 || out_count !== 4'd0 || out_valid !== 1'b0)
      $display("FAIL rst_mid_async got=s%0d c%0d v%0b exp=s0 c0 v0", out_sum, out_count, out_valid);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL rst_mid_no_valid got=%0d valid cycles exp=0", seen);
    else n_pass++;
    send_beat(4'd2, 1'b0, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_sum !== 4'd2 || out_ovf !== 1'b0 || out_count !== 4'd1)
      $display("FAIL rst_mid_new got=v%0b %0d/%0b/%0d exp=v1 2/0/1", out_valid, out_sum, out_ovf, out_count);
    else n_pass++;
    release_result();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 15; i++) send_beat(4'd0, 1'b0, 1'b0);
    n_total++;
    if (out_count !== 4'd15 || out_valid !== 1'b0)
      $display("FAIL sat_reach got=c%0d v%0b exp=c15 v0", out_count, out_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) send_beat(4'd0, 1'b0, 1'b0);
    send_beat(4'd0, 1'b0, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_count !== 4'd15 || out_sum !== 4'd0 || out_ovf !== 1'b0)
      $display("FAIL sat_hold got=v%0b c%0d s%0d o%0b exp=v1 c15 s0 o0", out_valid, out_count, out_sum, out_ovf);
    else n_pass++;
    release_result();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_accumulate();
    test_wrap();
    test_backpressure();
    test_carry_in();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
